decode_ctrl_pipe: RTL and testbench

- Registered RV32I decode/control stage between the IF/ID and ID/EX pipeline registers.
- Decodes the full base opcode set into a control bundle and holds it in an internal ID/EX control register.
- Detects load-use hazards and inserts a one-cycle bubble.
- Honours branch-kill and downstream stall, and keeps a saturating hazard-stall counter.

---
 rtl/decode_ctrl_pipe_if.sv | 44 ++++
 rtl/decode_ctrl_pipe.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_ctrl_pipe_if.sv
// Handshake and control-bundle bus for the RV32I decode/control stage.
//   master : IF/ID side plus the consumer of the ID/EX bundle (drives
//            in_valid, in_instr, stall_in, kill)
//   slave  : the decode stage (drives in_ready, out_valid, the control
//            bundle and hazard_cnt)
interface decode_ctrl_pipe_if #(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 16,
  parameter int ALU_FUN_W = 5
);
  logic                 in_valid;
  logic [XLEN-1:0]      in_instr;
  logic                 in_ready;
  logic                 stall_in;
  logic                 kill;
  logic                 out_valid;
  logic [ALU_FUN_W-1:0] alu_fun;
  logic                 op1_sel;
  logic                 op2_sel;
  logic [1:0]           wb_sel;
  logic                 reg_write_en;
  logic                 mem_val;
  logic                 mem_rw;
  logic [2:0]           br_type;
  logic [4:0]           rd;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic                 illegal;
  logic [CNT_W-1:0]     hazard_cnt;

  modport master (
    output in_valid, in_instr, stall_in, kill,
    input  in_ready, out_valid, alu_fun, op1_sel, op2_sel, wb_sel,
           reg_write_en, mem_val, mem_rw, br_type, rd, rs1, rs2, illegal,
           hazard_cnt
  );

  modport slave (
    input  in_valid, in_instr, stall_in, kill,
    output in_ready, out_valid, alu_fun, op1_sel, op2_sel, wb_sel,
           reg_write_en, mem_val, mem_rw, br_type, rd, rs1, rs2, illegal,
           hazard_cnt
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// Registered RV32I decode/control stage sitting between the IF/ID and ID/EX
// pipeline registers. Decodes in_instr into a control bundle held in an
// internal ID/EX control register, inserts a one-cycle bubble on load-use
// hazards, honours kill (flush) and stall_in (hold), and counts hazard
// bubbles in a saturating counter.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : decode_ctrl_pipe_if.slave (in_valid/in_instr/in_ready, stall_in,
//         kill, out_valid, control bundle, hazard_cnt)
// Optional: define DECODE_RV32M_EN to decode the RV32M multiply/divide ops;
// without it those encodings decode as illegal.
module decode_ctrl_pipe #(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 16,
  parameter int ALU_FUN_W = 5
) (
  input logic               clk,
  input logic               rst,
  decode_ctrl_pipe_if.slave bus
);

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL   = 5'd2,
    ALU_SLT   = 5'd3,
    ALU_SLTU  = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_OR    = 5'd8,
    ALU_AND   = 5'd9,
    ALU_COPY2 = 5'd10
  } alu_e;

  typedef struct packed {
    logic [4:0] alu;
    logic       op1_sel;
    logic       op2_sel;
    logic [1:0] wb_sel;
    logic       reg_write_en;
    logic       mem_val;
    logic       mem_rw;
    logic [2:0] br_type;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ctrl_t;

  logic [XLEN-1:0]  instr;
  logic [6:0]       opcode;
  logic [6:0]       funct7;
  logic [2:0]       funct3;
  logic [4:0]       rd_f, rs1_f, rs2_f;
  ctrl_t            dec;
  ctrl_t            ctrl_d, ctrl_q;
  logic             legal;
  logic             reads_rs1, reads_rs2;
  logic             load_pending, hazard;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  assign funct7 = instr[31:25];

  always_comb begin : decode
    dec       = '0;
    legal     = 1'b1;
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    dec.rd    = rd_f;
    dec.rs1   = rs1_f;
    dec.rs2   = rs2_f;
    case (opcode)
      OPC_OP: begin
        dec.reg_write_en = 1'b1;
        reads_rs1        = 1'b1;
        reads_rs2        = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'd0: dec.alu = ALU_ADD;
              3'd1: dec.alu = ALU_SLL;
              3'd2: dec.alu = ALU_SLT;
              3'd3: dec.alu = ALU_SLTU;
              3'd4: dec.alu = ALU_XOR;
              3'd5: dec.alu = ALU_SRL;
              3'd6: dec.alu = ALU_OR;
              3'd7: dec.alu = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'd0)      dec.alu = ALU_SUB;
            else if (funct3 == 3'd5) dec.alu = ALU_SRA;
            else                     legal   = 1'b0;
          end
          7'b0000001: begin
`ifdef DECODE_RV32M_EN
            // MUL..REMU occupy codes 16..23 in funct3 order
            dec.alu = {2'b10, funct3};
`else
            legal = 1'b0;
`endif
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec.reg_write_en = 1'b1;
        dec.op2_sel      = 1'b1;
        reads_rs1        = 1'b1;
        case (funct3)
          3'd0: dec.alu = ALU_ADD;
          3'd1: begin
            dec.alu = ALU_SLL;
            legal   = (funct7 == 7'b0000000);
          end
          3'd2: dec.alu = ALU_SLT;
          3'd3: dec.alu = ALU_SLTU;
          3'd4: dec.alu = ALU_XOR;
          3'd5: begin
            if (funct7 == 7'b0000000)      dec.alu = ALU_SRL;
            else if (funct7 == 7'b0100000) dec.alu = ALU_SRA;
            else                           legal   = 1'b0;
          end
          3'd6: dec.alu = ALU_OR;
          3'd7: dec.alu = ALU_AND;
        endcase
      end
      OPC_LOAD: begin
        dec.alu          = ALU_ADD;
        dec.op2_sel      = 1'b1;
        dec.wb_sel       = 2'd1;
        dec.mem_val      = 1'b1;
        dec.reg_write_en = 1'b1;
        reads_rs1        = 1'b1;
        legal = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
                (funct3 == 3'd4) || (funct3 == 3'd5);
      end
      OPC_STORE: begin
        dec.alu     = ALU_ADD;
        dec.op2_sel = 1'b1;
        dec.mem_val = 1'b1;
        dec.mem_rw  = 1'b1;
        reads_rs1   = 1'b1;
        reads_rs2   = 1'b1;
        legal       = (funct3 < 3'd3);
      end
      OPC_BRANCH: begin
        dec.alu   = ALU_SUB;
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
        case (funct3)
          3'd0:    dec.br_type = 3'd1;
          3'd1:    dec.br_type = 3'd2;
          3'd4:    dec.br_type = 3'd3;
          3'd5:    dec.br_type = 3'd4;
          3'd6:    dec.br_type = 3'd5;
          3'd7:    dec.br_type = 3'd6;
          default: legal       = 1'b0;
        endcase
      end
      OPC_JAL: begin
        dec.alu          = ALU_ADD;
        dec.op1_sel      = 1'b1;
        dec.op2_sel      = 1'b1;
        dec.wb_sel       = 2'd2;
        dec.br_type      = 3'd7;
        dec.reg_write_en = 1'b1;
      end
      OPC_JALR: begin
        dec.alu          = ALU_ADD;
        dec.op2_sel      = 1'b1;
        dec.wb_sel       = 2'd2;
        dec.br_type      = 3'd7;
        dec.reg_write_en = 1'b1;
        reads_rs1        = 1'b1;
        legal            = (funct3 == 3'd0);
      end
      OPC_LUI: begin
        dec.alu          = ALU_COPY2;
        dec.op2_sel      = 1'b1;
        dec.reg_write_en = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu          = ALU_ADD;
        dec.op1_sel      = 1'b1;
        dec.op2_sel      = 1'b1;
        dec.reg_write_en = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        // fence / ecall / csr ops travel down the pipe as NOPs
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec         = '0;
      dec.rd      = rd_f;
      dec.rs1     = rs1_f;
      dec.rs2     = rs2_f;
      dec.illegal = 1'b1;
    end
  end

  // A load sitting in ID/EX whose destination the incoming instruction needs.
  assign load_pending = valid_q & ctrl_q.mem_val & ~ctrl_q.mem_rw &
                        (ctrl_q.rd != 5'd0);
  assign hazard = load_pending & bus.in_valid &
                  ((reads_rs1 & (rs1_f == ctrl_q.rd)) |
                   (reads_rs2 & (rs2_f == ctrl_q.rd)));

  assign bus.in_ready = ~bus.kill & ~hazard & ~bus.stall_in;

  always_comb begin : next_state
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    if (bus.kill) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (bus.stall_in) begin
      // hold everything
    end else if (hazard) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (bus.in_valid) begin
      valid_d = 1'b1;
      ctrl_d  = dec;
    end else begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.alu_fun      = ALU_FUN_W'(ctrl_q.alu);
  assign bus.op1_sel      = ctrl_q.op1_sel;
  assign bus.op2_sel      = ctrl_q.op2_sel;
  assign bus.wb_sel       = ctrl_q.wb_sel;
  assign bus.reg_write_en = ctrl_q.reg_write_en;
  assign bus.mem_val      = ctrl_q.mem_val;
  assign bus.mem_rw       = ctrl_q.mem_rw;
  assign bus.br_type      = ctrl_q.br_type;
  assign bus.rd           = ctrl_q.rd;
  assign bus.rs1          = ctrl_q.rs1;
  assign bus.rs2          = ctrl_q.rs2;
  assign bus.illegal      = ctrl_q.illegal;
  assign bus.hazard_cnt   = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench for decode_ctrl_pipe: directed cases followed by random
// instruction streams with random stall/kill/reset, checked against a
// behavioural reference decoder and pipeline-stage model.
module tb_decode_ctrl_pipe;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_ctrl_pipe_if #(.XLEN(32), .CNT_W(CNT_W), .ALU_FUN_W(5)) bus ();
  decode_ctrl_pipe #(.XLEN(32), .CNT_W(CNT_W), .ALU_FUN_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [4:0] alu;
    logic       op1;
    logic       op2;
    logic [1:0] wb;
    logic       rwe;
    logic       mv;
    logic       rw;
    logic [2:0] br;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       ill;
  } exp_t;

  int n_vec = 0;
  int n_bad = 0;

  // ALU code by funct3 for the base (funct7=0) OP encodings
  int base_alu [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  // br_type by funct3; 0 marks an unused funct3
  int br_of_f3 [8] = '{1, 2, 0, 0, 3, 4, 5, 6};

  exp_t exp_q[$];
  bit   m_valid = 0;
  bit   m_held  = 0;
  exp_t m_out   = '0;
  int   m_cnt   = 0;
  exp_t last    = '0;
  bit   have_last = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit ok;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; ok = 1;
    e = '0;
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    case (op)
      7'h33: begin
        e.rwe = 1;
        if (f7 == 7'h00) e.alu = 5'(base_alu[f3]);
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.alu = 5'(base_alu[f3] + 1);
`ifdef DECODE_RV32M_EN
        else if (f7 == 7'h01) e.alu = 5'(16 + int'(f3));
`endif
        else ok = 0;
      end
      7'h13: begin
        e.rwe = 1; e.op2 = 1; e.alu = 5'(base_alu[f3]);
        if (f3 == 3'd1 && f7 != 7'h00) ok = 0;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) e.alu = 5'(base_alu[5] + 1);
          else if (f7 != 7'h00) ok = 0;
        end
      end
      7'h03: begin
        e.op2 = 1; e.wb = 2'd1; e.mv = 1; e.rwe = 1;
        ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      end
      7'h23: begin e.op2 = 1; e.mv = 1; e.rw = 1; ok = (f3 < 3'd3); end
      7'h63: begin e.alu = 5'd1; e.br = 3'(br_of_f3[f3]); ok = (br_of_f3[f3] != 0); end
      7'h6F: begin e.op1 = 1; e.op2 = 1; e.wb = 2'd2; e.br = 3'd7; e.rwe = 1; end
      7'h67: begin e.op2 = 1; e.wb = 2'd2; e.br = 3'd7; e.rwe = 1; ok = (f3 == 3'd0); end
      7'h37: begin e.alu = 5'd10; e.op2 = 1; e.rwe = 1; end
      7'h17: begin e.op1 = 1; e.op2 = 1; e.rwe = 1; end
      7'h0F, 7'h73: ;
      default: ok = 0;
    endcase
    if (!ok) begin
      e = '0;
      e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
      e.ill = 1;
    end
    return e;
  endfunction

  function automatic bit reads_rs1(input logic [31:0] ins);
    return ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  function automatic bit reads_rs2(input logic [31:0] ins);
    return ins[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction

  // One clock: drive inputs, check in_ready, advance the model at the edge,
  // then check out_valid and the hazard counter.
  task automatic cycle(input bit v, input logic [31:0] ins, input bit st,
                       input bit kl, input bit r);
    bit haz, rdy;
    bus.in_valid = v; bus.in_instr = ins; bus.stall_in = st; bus.kill = kl; rst = r;
    #1;
    haz = m_valid && m_out.mv && !m_out.rw && (m_out.rd != 0) && v &&
          ((reads_rs1(ins) && ins[19:15] == m_out.rd) ||
           (reads_rs2(ins) && ins[24:20] == m_out.rd));
    rdy = !kl && !haz && !st;
    if (!r) check("in_ready", 32'(bus.in_ready), 32'(rdy));
    @(posedge clk);
    m_held = 0;
    if (r) begin
      m_valid = 0; m_cnt = 0;
    end else if (kl) begin
      m_valid = 0;
    end else if (st) begin
      m_held = m_valid;
    end else if (haz) begin
      m_valid = 0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else if (v) begin
      m_valid = 1;
      m_out = ref_decode(ins);
      exp_q.push_back(m_out);
    end else begin
      m_valid = 0;
    end
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("hazard_cnt", 32'(bus.hazard_cnt), 32'(m_cnt));
  endtask

  task automatic idle();
    cycle(0, 32'h0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] raw;
    rd = 5'($urandom_range(0, 3));
    r1 = 5'($urandom_range(0, 3));
    r2 = 5'($urandom_range(0, 3));
    f3 = 3'($urandom);
    raw = $urandom;
    case ($urandom_range(0, 11))
      0:  return {7'h00, r2, r1, f3, rd, 7'h33};
      1:  return {7'h20, r2, r1, f3, rd, 7'h33};
      2:  return {7'h01, r2, r1, f3, rd, 7'h33};
      3: begin
        f7 = ($urandom_range(0, 2) == 0) ? 7'h20 : (($urandom_range(0, 3) == 0) ? raw[31:25] : 7'h00);
        return {f7, r2, r1, f3, rd, 7'h13};
      end
      4:  return {raw[31:20], r1, f3, rd, 7'h03};
      5:  return {raw[31:25], r2, r1, f3, raw[11:7], 7'h23};
      6:  return {raw[31:25], r2, r1, f3, raw[11:7], 7'h63};
      7:  return {raw[31:12], rd, 7'h6F};
      8:  return {raw[31:20], r1, f3, rd, 7'h67};
      9:  return {raw[31:12], rd, (raw[0] ? 7'h37 : 7'h17)};
      10: return raw[1] ? 32'h0000000F : 32'h00000073;
      default: return raw;
    endcase
  endfunction

  // Monitor: every live ID/EX value is compared with the scoreboard; a held
  // (stalled) value is compared again with the entry already popped.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (m_held && have_last) begin
        check("bundle_held", 32'({bus.alu_fun, bus.op1_sel, bus.op2_sel, bus.wb_sel,
              bus.reg_write_en, bus.mem_val, bus.mem_rw, bus.br_type, bus.rd,
              bus.rs1, bus.rs2, bus.illegal}), 32'(last));
      end else if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(1), 32'(0));
      end else begin
        last = exp_q.pop_front();
        have_last = 1;
        check("bundle", 32'({bus.alu_fun, bus.op1_sel, bus.op2_sel, bus.wb_sel,
              bus.reg_write_en, bus.mem_val, bus.mem_rw, bus.br_type, bus.rd,
              bus.rs1, bus.rs2, bus.illegal}), 32'(last));
      end
    end
  end

  localparam logic [31:0] I_ADD = 32'h002081B3;  // ADD x3,x1,x2
  localparam logic [31:0] I_LW  = 32'h0000A283;  // LW x5,0(x1)
  localparam logic [31:0] I_USE = 32'h00528333;  // ADD x6,x5,x5
  localparam logic [31:0] I_MUL = 32'h022081B3;  // MUL x3,x1,x2

  initial begin
    cycle(0, 32'h0, 0, 0, 1);
    cycle(0, 32'h0, 0, 0, 1);

    cycle(1, I_ADD, 0, 0, 0);
    idle();

    // load-use: bubble, then the consumer is accepted
    cycle(1, I_LW, 0, 0, 0);
    cycle(1, I_USE, 0, 0, 0);
    cycle(1, I_USE, 0, 0, 0);
    idle();

    // stall during the hazard cycle holds the load
    cycle(1, I_LW, 0, 0, 0);
    cycle(1, I_USE, 1, 0, 0);
    cycle(1, I_USE, 1, 0, 0);
    cycle(1, I_USE, 0, 0, 0);
    cycle(1, I_USE, 0, 0, 0);
    idle();

    // kill, and kill together with stall
    cycle(1, I_ADD, 0, 1, 0);
    cycle(1, I_ADD, 0, 0, 0);
    cycle(1, I_ADD, 1, 1, 0);
    idle();

    // illegal and RV32M encodings
    cycle(1, 32'hFFFFFFFF, 0, 0, 0);
    check("ffff_ill_rwe_mv", 32'({bus.illegal, bus.reg_write_en, bus.mem_val}), 32'h4);
    cycle(1, I_MUL, 0, 0, 0);
`ifdef DECODE_RV32M_EN
    check("mul_alu_fun", 32'(bus.alu_fun), 32'd16);
`else
    check("mul_illegal", 32'(bus.illegal), 32'd1);
`endif
    idle();

    // reset mid-stall and mid-hazard
    cycle(1, I_ADD, 0, 0, 0);
    cycle(0, 32'h0, 1, 0, 0);
    cycle(0, 32'h0, 1, 0, 1);
    cycle(1, I_LW, 0, 0, 0);
    cycle(1, I_USE, 0, 0, 1);
    idle();

    // five hazards against a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      cycle(1, I_LW, 0, 0, 0);
      cycle(1, I_USE, 0, 0, 0);
      cycle(1, I_USE, 0, 0, 0);
    end
    check("hazard_cnt_sat", 32'(bus.hazard_cnt), 32'(CNT_MAX));
    idle();

    // random streams
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 3) != 0), rand_instr(),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 199) == 0));
    end
    idle();
    idle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
